// File: rtl/eth_init_seq.sv
// rtl/eth_init_seq.sv - table-driven register initialisation sequencer for the Ethernet controller
// Optional ETH_INIT_IRQ_EN: appends an ISR clear and RX interrupt enable to the table.
module eth_init_seq #(
   parameter logic [47:0] MAC_ADDR   = 48'h0010_A1B2_C3D4,
   parameter int unsigned POLL_LIMIT = 255,
   parameter int unsigned TIMEOUT    = 63
) (
   input  logic        clk40m,
   input  logic        reset,
   input  logic        start,
   output logic        reg_wr,
   output logic [7:0]  reg_offset,
   output logic        reg_length,
   output logic [15:0] reg_wdata,
   output logic        reg_new_cmd,
   input  logic [15:0] reg_rdata,
   input  logic [3:0]  reg_state,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] chip_id,
   output logic [3:0]  step
);
   localparam logic [3:0]  ENG_WAIT = 4'b1001;
   localparam logic [7:0]  POLL_LIM = 8'(POLL_LIMIT);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {OP_WRITE, OP_POLL, OP_END} op_e;
   typedef enum logic [3:0] {
      S_IDLE, S_ARM, S_ISSUE, S_LEAVE, S_RETURN, S_CHECK, S_NEXT, S_FINISH, S_FAIL
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  step_q, step_d;
   logic [7:0]  poll_q, poll_d;
   logic [15:0] tmo_q, tmo_d;
   logic        wr_q, wr_d;
   logic [7:0]  off_q, off_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;
   logic [15:0] chip_q, chip_d;
   logic        err_q, err_d;
   logic        done_q, done_d;

   op_e         ent_op;
   logic [7:0]  ent_off;
   logic [15:0] ent_data;
   logic [15:0] ent_mask;

   always_comb begin
      ent_op   = OP_END;
      ent_off  = 8'h00;
      ent_data = 16'h0000;
      ent_mask = 16'hFFFF;
      case (step_q)
         4'd0: begin ent_op = OP_POLL;  ent_off = 8'hC0; ent_data = 16'h8870; ent_mask = 16'hFFF0; end
         4'd1: begin ent_op = OP_WRITE; ent_off = 8'h10; ent_data = MAC_ADDR[15:0];  end
         4'd2: begin ent_op = OP_WRITE; ent_off = 8'h12; ent_data = MAC_ADDR[31:16]; end
         4'd3: begin ent_op = OP_WRITE; ent_off = 8'h14; ent_data = MAC_ADDR[47:32]; end
         4'd4: begin ent_op = OP_WRITE; ent_off = 8'h70; ent_data = 16'h01EE; end
         4'd5: begin ent_op = OP_WRITE; ent_off = 8'h74; ent_data = 16'h7CE0; end
`ifdef ETH_INIT_IRQ_EN
         4'd6: begin ent_op = OP_WRITE; ent_off = 8'h92; ent_data = 16'hFFFF; end
         4'd7: begin ent_op = OP_WRITE; ent_off = 8'h90; ent_data = 16'h2000; end
`else
         4'd6: begin ent_op = OP_WRITE; ent_off = 8'h90; ent_data = 16'h0000; end
`endif
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      poll_d  = poll_q;
      tmo_d   = tmo_q;
      wr_d    = wr_q;
      off_d   = off_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      chip_d  = chip_q;
      err_d   = err_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               err_d   = 1'b0;
               step_d  = 4'd0;
               poll_d  = 8'd0;
               state_d = S_ARM;
            end
         end
         S_ARM: begin
            wr_d    = (ent_op == OP_WRITE);
            off_d   = ent_off;
            wdata_d = ent_data;
            // Never issue into an engine that is still finishing a transaction.
            if (ent_op == OP_END)            state_d = S_FINISH;
            else if (reg_state == ENG_WAIT)  state_d = S_ISSUE;
         end
         S_ISSUE: begin
            tmo_d   = 16'd0;
            state_d = S_LEAVE;
         end
         S_LEAVE: begin
            tmo_d = tmo_q + 16'd1;
            if (reg_state != ENG_WAIT)   state_d = S_RETURN;
            else if (tmo_q == TMO_LAST)  state_d = S_FAIL;
         end
         S_RETURN: begin
            tmo_d = tmo_q + 16'd1;
            if (reg_state == ENG_WAIT) begin
               rdata_d = reg_rdata;
               state_d = (ent_op == OP_POLL) ? S_CHECK : S_NEXT;
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_FAIL;
            end
         end
         S_CHECK: begin
            if (step_q == 4'd0) chip_d = rdata_q;
            if ((rdata_q & ent_mask) == ent_data) begin
               state_d = S_NEXT;
            end else begin
               poll_d  = poll_q + 8'd1;
               state_d = (poll_q + 8'd1 == POLL_LIM) ? S_FAIL : S_ARM;
            end
         end
         S_NEXT: begin
            step_d  = step_q + 4'd1;
            poll_d  = 8'd0;
            state_d = S_ARM;
         end
         S_FINISH: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         S_FAIL: begin
            err_d   = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk40m) begin
      if (!reset) begin
         state_q <= S_IDLE;
         step_q  <= 4'd0;
         poll_q  <= 8'd0;
         tmo_q   <= 16'd0;
         wr_q    <= 1'b0;
         off_q   <= 8'h00;
         wdata_q <= 16'h0000;
         rdata_q <= 16'h0000;
         chip_q  <= 16'h0000;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         poll_q  <= poll_d;
         tmo_q   <= tmo_d;
         wr_q    <= wr_d;
         off_q   <= off_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         chip_q  <= chip_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign reg_wr      = wr_q;
   assign reg_offset  = off_q;
   assign reg_length  = 1'b1;
   assign reg_wdata   = wdata_q;
   assign reg_new_cmd = (state_q == S_ISSUE);
   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign error       = err_q;
   assign chip_id     = chip_q;
   assign step        = step_q;
endmodule

// File: tb/tb_eth_init_seq.sv
// tb/tb_eth_init_seq.sv - self-checking bench for eth_init_seq with a register I/O engine model
module tb_eth_init_seq;
   localparam logic [47:0] MAC   = 48'h0010_A1B2_C3D4;
   localparam logic [3:0]  WAITS = 4'b1001;
   localparam logic [49:0] RESET_VEC = {1'b0, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0};

   typedef struct packed {
      logic        wr;
      logic [7:0]  off;
      logic [15:0] data;
   } txn_t;

   logic        clk40m = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        reg_wr, reg_length, reg_new_cmd, busy, done, error;
   logic [7:0]  reg_offset;
   logic [15:0] reg_wdata, chip_id;
   logic [3:0]  step;
   logic [15:0] reg_rdata = 16'h0000;
   logic [3:0]  reg_state = WAITS;

   int n_cmp = 0;
   int n_fail = 0;

   txn_t        got_q[$];
   txn_t        exp_q[$];
   txn_t        t_new;
   logic [15:0] script[$];
   logic [15:0] poll_resp[$];
   logic [15:0] poll_default = 16'h0000;
   int          lat_min = 6;
   int          lat_max = 10;
   bit          hang_on_12 = 1'b0;
   bit          eng_hung = 1'b0;
   int          eng_cnt = 0;
   int          wide_pulses = 0;
   int          bad_issue = 0;
   int          done_cnt = 0;
   logic        prev_cmd = 1'b0;

   eth_init_seq dut (
      .clk40m      (clk40m),
      .reset       (reset),
      .start       (start),
      .reg_wr      (reg_wr),
      .reg_offset  (reg_offset),
      .reg_length  (reg_length),
      .reg_wdata   (reg_wdata),
      .reg_new_cmd (reg_new_cmd),
      .reg_rdata   (reg_rdata),
      .reg_state   (reg_state),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .chip_id     (chip_id),
      .step        (step)
   );

   always #5 clk40m = ~clk40m;

   // Engine model: busy for a random 6..10 cycles per command, or forever on a hung write to 12.
   always @(negedge clk40m) begin
      if (reg_new_cmd === 1'b1 && prev_cmd === 1'b1) wide_pulses++;
      prev_cmd = reg_new_cmd;
      if (done === 1'b1) done_cnt++;
      if (reg_new_cmd === 1'b1 && reg_state !== WAITS) bad_issue++;
      if (eng_hung) begin
         if (!hang_on_12) begin
            eng_hung  = 1'b0;
            reg_state = WAITS;
         end
      end else if (eng_cnt > 0) begin
         eng_cnt--;
         if (eng_cnt == 0) reg_state = WAITS;
      end else if (reg_new_cmd === 1'b1) begin
         t_new.wr   = reg_wr;
         t_new.off  = reg_offset;
         t_new.data = reg_wr ? reg_wdata : 16'h0000;
         got_q.push_back(t_new);
         if (!reg_wr) reg_rdata = (poll_resp.size() > 0) ? poll_resp.pop_front() : poll_default;
         reg_state = 4'b0010;
         if (hang_on_12 && reg_wr && reg_offset == 8'h12) eng_hung = 1'b1;
         else eng_cnt = $urandom_range(lat_max, lat_min);
      end
   end

   function automatic txn_t mk(input logic wr, input logic [7:0] off, input logic [15:0] data);
      txn_t t;
      t.wr = wr; t.off = off; t.data = data;
      return t;
   endfunction

   function automatic logic [49:0] outs();
      return {reg_new_cmd, reg_wr, reg_offset, reg_length, reg_wdata, busy, done, error, chip_id, step};
   endfunction

   // Reference: reads of C0 until (v & FFF0)==8870 or 255 tries, then the fixed write list.
   function automatic void build_expected(output logic [15:0] chip, output bit pass);
      logic [15:0] v;
      exp_q.delete();
      pass = 1'b0;
      chip = 16'h0000;
      for (int i = 0; i < 255 && !pass; i++) begin
         v = (i < script.size()) ? script[i] : poll_default;
         exp_q.push_back(mk(1'b0, 8'hC0, 16'h0000));
         chip = v;
         pass = ((v & 16'hFFF0) == 16'h8870);
      end
      if (pass) begin
         exp_q.push_back(mk(1'b1, 8'h10, MAC[15:0]));
         exp_q.push_back(mk(1'b1, 8'h12, MAC[31:16]));
         exp_q.push_back(mk(1'b1, 8'h14, MAC[47:32]));
         exp_q.push_back(mk(1'b1, 8'h70, 16'h01EE));
         exp_q.push_back(mk(1'b1, 8'h74, 16'h7CE0));
`ifdef ETH_INIT_IRQ_EN
         exp_q.push_back(mk(1'b1, 8'h92, 16'hFFFF));
         exp_q.push_back(mk(1'b1, 8'h90, 16'h2000));
`else
         exp_q.push_back(mk(1'b1, 8'h90, 16'h0000));
`endif
      end
   endfunction

   function automatic int txn_diff();
      if (got_q.size() != exp_q.size())
         return (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return i;
      return -1;
   endfunction

   task automatic run_seq(input int bound, output int cyc);
      got_q.delete();
      done_cnt = 0;
      cyc = 0;
      poll_resp = script;
      start = 1'b1;
      @(negedge clk40m);
      start = 1'b0;
      while (busy === 1'b1 && cyc < bound) begin
         @(negedge clk40m);
         cyc++;
      end
      @(negedge clk40m);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk40m);
      n_cmp++;
      if (outs() !== RESET_VEC) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h, expected %h", outs(), RESET_VEC);
      end
      reset = 1'b1;
      repeat (2) @(negedge clk40m);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_busy: got %b, expected 0", busy);
      end
   endtask

   task automatic test_poll_first();
      logic [15:0] chip; bit pass; int c, d;
      script = '{16'h8872};
      poll_default = 16'h8872;
      build_expected(chip, pass);
      run_seq(2000, c);
      d = txn_diff();
      n_cmp++;
      if (d != -1) begin
         n_fail++;
         $display("FAIL first_txns: diff at %0d, got %0d txns, expected %0d", d, got_q.size(), exp_q.size());
      end
      n_cmp++;
      if (chip_id !== chip) begin
         n_fail++;
         $display("FAIL first_chip_id: got %h, expected %h", chip_id, chip);
      end
      n_cmp++;
      if (done_cnt != 1) begin
         n_fail++;
         $display("FAIL first_done: got %0d pulses, expected 1", done_cnt);
      end
      n_cmp++;
      if ({error, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL first_err_busy: got %b, expected 00", {error, busy});
      end
   endtask

   task automatic test_poll_retry();
      logic [15:0] chip; bit pass; int c, d;
      script = '{16'h0000, 16'h0000, 16'h0000, 16'h8870};
      poll_default = 16'h0000;
      build_expected(chip, pass);
      run_seq(3000, c);
      d = txn_diff();
      n_cmp++;
      if (d != -1) begin
         n_fail++;
         $display("FAIL retry_txns: diff at %0d, got %0d txns, expected %0d", d, got_q.size(), exp_q.size());
      end
      n_cmp++;
      if (done_cnt != 1 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL retry_done: got done=%0d error=%b, expected 1 and 0", done_cnt, error);
      end
      n_cmp++;
      if (chip_id !== 16'h8870) begin
         n_fail++;
         $display("FAIL retry_chip_id: got %h, expected 8870", chip_id);
      end
   endtask

   task automatic test_poll_exhaust();
      logic [15:0] chip; bit pass; int c, d;
      script.delete();
      poll_default = 16'h1234;
      lat_min = 6; lat_max = 6;
      build_expected(chip, pass);
      run_seq(8000, c);
      lat_min = 6; lat_max = 10;
      d = txn_diff();
      n_cmp++;
      if (d != -1) begin
         n_fail++;
         $display("FAIL exhaust_txns: diff at %0d, got %0d txns, expected %0d", d, got_q.size(), exp_q.size());
      end
      n_cmp++;
      if ({error, busy, step} !== {1'b1, 1'b0, 4'd0}) begin
         n_fail++;
         $display("FAIL exhaust_status: got err=%b busy=%b step=%0d, expected 1 0 0", error, busy, step);
      end
      n_cmp++;
      if (done_cnt != 0) begin
         n_fail++;
         $display("FAIL exhaust_done: got %0d pulses, expected 0", done_cnt);
      end
      n_cmp++;
      if (chip_id !== chip) begin
         n_fail++;
         $display("FAIL exhaust_chip_id: got %h, expected %h", chip_id, chip);
      end
   endtask

   task automatic test_timeout();
      logic [15:0] chip; bit pass; int c, d;
      script = '{16'h8870};
      poll_default = 16'h8870;
      build_expected(chip, pass);
      while (exp_q.size() > 3) void'(exp_q.pop_back());
      poll_resp = script;
      got_q.delete();
      hang_on_12 = 1'b1;
      start = 1'b1;
      @(negedge clk40m);
      start = 1'b0;
      c = 0;
      while (got_q.size() < 3 && c < 1000) begin @(negedge clk40m); c++; end
      c = 0;
      while (error !== 1'b1 && c < 200) begin @(negedge clk40m); c++; end
      n_cmp++;
      if (c < 63 || c > 67) begin
         n_fail++;
         $display("FAIL timeout_latency: got %0d cycles, expected 63..67", c);
      end
      n_cmp++;
      if ({busy, step} !== {1'b0, 4'd2}) begin
         n_fail++;
         $display("FAIL timeout_status: got busy=%b step=%0d, expected 0 2", busy, step);
      end
      d = txn_diff();
      n_cmp++;
      if (d != -1) begin
         n_fail++;
         $display("FAIL timeout_txns: diff at %0d, got %0d txns, expected %0d", d, got_q.size(), exp_q.size());
      end
      hang_on_12 = 1'b0;
      repeat (2) @(negedge clk40m);
      build_expected(chip, pass);
      run_seq(3000, c);
      n_cmp++;
      if (error !== 1'b0 || done_cnt != 1) begin
         n_fail++;
         $display("FAIL timeout_rerun: got error=%b done=%0d, expected 0 1", error, done_cnt);
      end
      d = txn_diff();
      n_cmp++;
      if (d != -1) begin
         n_fail++;
         $display("FAIL timeout_rerun_txns: diff at %0d, got %0d, expected %0d", d, got_q.size(), exp_q.size());
      end
   endtask

   task automatic test_reset_restart();
      logic [15:0] chip; bit pass; int c, d;
      script = '{16'h8871};
      poll_default = 16'h8871;
      lat_min = 20; lat_max = 20;
      poll_resp = script;
      got_q.delete();
      start = 1'b1;
      @(negedge clk40m);
      start = 1'b0;
      c = 0;
      while (got_q.size() < 4 && c < 2000) begin @(negedge clk40m); c++; end
      repeat (2) @(negedge clk40m);
      reset = 1'b0;
      @(negedge clk40m);
      n_cmp++;
      if (outs() !== RESET_VEC) begin
         n_fail++;
         $display("FAIL midwrite_reset: got %h, expected %h", outs(), RESET_VEC);
      end
      reset = 1'b1;
      build_expected(chip, pass);
      poll_resp = script;
      got_q.delete();
      done_cnt = 0;
      start = 1'b1;
      @(negedge clk40m);
      start = 1'b0;
      n_cmp++;
      if ({busy, step} !== {1'b1, 4'd0}) begin
         n_fail++;
         $display("FAIL restart_state: got busy=%b step=%0d, expected 1 0", busy, step);
      end
      repeat (3) @(negedge clk40m);
      n_cmp++;
      if (got_q.size() != 0) begin
         n_fail++;
         $display("FAIL restart_early_cmd: got %0d commands, expected 0 while engine busy", got_q.size());
      end
      c = 0;
      while (busy === 1'b1 && c < 4000) begin @(negedge clk40m); c++; end
      @(negedge clk40m);
      lat_min = 6; lat_max = 10;
      d = txn_diff();
      n_cmp++;
      if (d != -1 || done_cnt != 1) begin
         n_fail++;
         $display("FAIL restart_run: diff at %0d, done=%0d, expected -1 and 1", d, done_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] chip; bit pass; int c, d;
      txn_t one[$];
      script.delete();
      poll_default = 16'h887F;
      build_expected(chip, pass);
      one = exp_q;
      foreach (one[i]) exp_q.push_back(one[i]);
      got_q.delete();
      done_cnt = 0;
      start = 1'b1;
      c = 0;
      while (done !== 1'b1 && c < 2000) begin @(negedge clk40m); c++; end
      @(negedge clk40m);
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_restart: got busy=%b, expected 1", busy);
      end
      c = 0;
      while (busy === 1'b1 && c < 2000) begin @(negedge clk40m); c++; end
      @(negedge clk40m);
      n_cmp++;
      if (done_cnt != 2) begin
         n_fail++;
         $display("FAIL b2b_done: got %0d pulses, expected 2", done_cnt);
      end
      d = txn_diff();
      n_cmp++;
      if (d != -1) begin
         n_fail++;
         $display("FAIL b2b_txns: diff at %0d, got %0d, expected %0d", d, got_q.size(), exp_q.size());
      end
   endtask

   task automatic test_random();
      logic [15:0] chip, v; bit pass; int c, d, nbad;
      for (int it = 0; it < 8; it++) begin
         script.delete();
         nbad = $urandom_range(4, 0);
         for (int k = 0; k < nbad; k++) begin
            v = 16'($urandom);
            if ((v & 16'hFFF0) == 16'h8870) v = v ^ 16'h0100;
            script.push_back(v);
         end
         script.push_back({12'h887, 4'($urandom)});
         poll_default = 16'($urandom);
         lat_max = $urandom_range(12, 6);
         build_expected(chip, pass);
         run_seq(3000, c);
         d = txn_diff();
         n_cmp++;
         if (d != -1) begin
            n_fail++;
            $display("FAIL rand%0d_txns: diff at %0d, got %0d, expected %0d", it, d, got_q.size(), exp_q.size());
         end
         n_cmp++;
         if (chip_id !== chip) begin
            n_fail++;
            $display("FAIL rand%0d_chip_id: got %h, expected %h", it, chip_id, chip);
         end
         n_cmp++;
         if (done_cnt != 1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL rand%0d_done: got done=%0d error=%b, expected 1 0", it, done_cnt, error);
         end
      end
      lat_max = 10;
   endtask

   task automatic test_cmd_pulses();
      n_cmp++;
      if (wide_pulses != 0) begin
         n_fail++;
         $display("FAIL new_cmd_width: got %0d wide pulses, expected 0", wide_pulses);
      end
      n_cmp++;
      if (bad_issue != 0) begin
         n_fail++;
         $display("FAIL new_cmd_busy_engine: got %0d, expected 0", bad_issue);
      end
   endtask

   initial begin
      test_reset();
      test_poll_first();
      test_poll_retry();
      test_poll_exhaust();
      test_timeout();
      test_reset_restart();
      test_back_to_back();
      test_random();
      test_cmd_pulses();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/eth_init_seq.md
# eth_init_seq

Register-level initialisation sequencer for the Ethernet controller, sitting directly upstream of the register I/O engine that drives CMD/RDN/WRN/SD. On `start` it walks a fixed, in-RTL table of register operations: chip-ID poll, MAC address load, TX/RX configuration, interrupt setup. Each entry is issued as one command to the register I/O engine, and completion is tracked by watching that engine's `state` output. It reports `busy`, `done` or `error`, and captures the chip ID for the host logic.

## Interface
Parameters:
- `MAC_ADDR`, default 48'h0010_A1B2_C3D4: station MAC address loaded into MARL/MARM/MARH.
- `POLL_LIMIT`, default 255: maximum reads of a POLL entry before failure.
- `TIMEOUT`, default 63: maximum cycles for one register transaction to complete.

Ports:
- `clk40m` in 1: single clock for the whole block.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: level; sampled in IDLE only.
- `reg_wr` out 1: to engine `WR`; 1 = write, 0 = read.
- `reg_offset` out 8: to engine `offset`.
- `reg_length` out 1: to engine `length`; always 1 (word).
- `reg_wdata` out 16: to engine `writeData`.
- `reg_new_cmd` out 1: to engine `NewCommand`; single-cycle pulse.
- `reg_rdata` in 16: from engine `readData`.
- `reg_state` in 4: from engine `state`; value 4'b1001 = engine idle (Wait).
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle pulse on successful completion.
- `error` out 1: sticky failure flag; cleared by the next accepted `start` or by reset.
- `chip_id` out 16: last value read at entry 0.
- `step` out 4: index of the current table entry.

## Operation
- Each table entry is {op, offset, data, mask}. Ops:
  - WRITE: write `data` to `offset`.
  - POLL: read `offset` until `(rdata & mask) == data`.
  - END: terminate the sequence.
- Table (offsets hex):
  - 0 POLL C0 data 8870 mask FFF0.
  - 1 WRITE 10 = MAC[15:0].
  - 2 WRITE 12 = MAC[31:16].
  - 3 WRITE 14 = MAC[47:32].
  - 4 WRITE 70 = 01EE.
  - 5 WRITE 74 = 7CE0.
  - 6 WRITE 90 = 0000.
  - 7 END.
- FSM states: IDLE, ARM, ISSUE, LEAVE, RETURN, CHECK, NEXT, FINISH, FAIL.
- IDLE:
  - If `start`=1, clear `error`, set `step`=0 and go to ARM.
- ARM:
  - Drive `reg_wr`, `reg_offset` and `reg_wdata` from the current entry.
  - If the entry is END, go to FINISH.
  - Otherwise wait until `reg_state`==4'b1001, then go to ISSUE.
- ISSUE:
  - Assert `reg_new_cmd` for exactly this one cycle, then go to LEAVE.
- LEAVE:
  - Wait for `reg_state`!=4'b1001, then go to RETURN.
- RETURN:
  - Wait for `reg_state`==4'b1001; `reg_rdata` is valid on that cycle.
  - WRITE entries go to NEXT; POLL entries go to CHECK.
- CHECK:
  - At step 0, latch `chip_id` from `reg_rdata`.
  - On match, go to NEXT.
  - On mismatch, increment the poll counter; if it reaches `POLL_LIMIT`, go to FAIL, else go to ARM.
- NEXT:
  - `step`+1, clear the poll counter, go to ARM.
- FINISH:
  - Pulse `done`, return to IDLE.
- FAIL:
  - Set `error`, return to IDLE. `step` holds the failing index.
- Operand outputs (`reg_wr`, `reg_offset`, `reg_wdata`) stay stable from ARM through RETURN.

## Timing
- Reset values:
  - State IDLE.
  - `reg_new_cmd`=0, `reg_wr`=0, `reg_offset`=0, `reg_length`=1, `reg_wdata`=0.
  - `busy`=0, `done`=0, `error`=0, `chip_id`=0, `step`=0.
  - Poll counter and timeout counter = 0.
- `busy`=1 in every state except IDLE; it drops on the cycle `done` or `error` becomes visible.
- `start` is ignored while `busy`. `start` held high after completion restarts the sequence on the next IDLE cycle.
- Timeout:
  - The counter resets on entering LEAVE and counts in LEAVE and RETURN.
  - At `TIMEOUT` cycles without reaching the end of RETURN, go to FAIL.
- Nominal cost is 7–8 cycles per WRITE or single POLL read, plus 2 overhead cycles.
- Reset mid-operation: the block returns to IDLE next edge with `reg_new_cmd`=0. ARM's idle-wait guarantees no command is issued into an engine that is still mid-transaction.
- Poll counter width is 8 bits.
- `reg_state` leaving 4'b1001 and returning within the same observed cycle cannot occur, since the engine's minimum transaction is 6 cycles.

## Configuration
- Macro: `ETH_INIT_IRQ_EN`.
- When defined, the table is:
  - 0–5 as above.
  - 6 WRITE 92 = FFFF (clear ISR).
  - 7 WRITE 90 = 2000 (enable RX interrupt).
  - 8 END.
- When undefined, the table is exactly as listed in Operation; entry 6 writes IER=0000, with no ISR clear.

## Test plan
- Chip-ID poll passes first time:
  - Engine model returns 8872 at C0 on the first read.
  - `chip_id`=8872, and 6 writes follow in order: 10/C3D4, 12/A1B2, 14/0010, 70/01EE, 74/7CE0, 90/0000.
  - `done` pulses once; `error`=0.
- Poll retries then passes:
  - Model returns 0000 three times, then 8870.
  - Exactly 4 reads of C0 occur, then the write sequence runs.
  - `done`=1.
- Poll exhausts:
  - Model always returns 1234.
  - Exactly 255 reads occur, then `error`=1, `step`=0, `busy`=0, and no writes are issued.
- Timeout:
  - Model holds `reg_state` at a non-Wait value at step 2.
  - `error`=1 and `step`=2 after 63 cycles.
  - A following `start` clears `error` and the sequence reruns.
- Reset and restart:
  - Assert `reset` low mid-write at step 3.
  - All outputs return to their reset values next edge.
  - A new `start` begins at step 0, and only after `reg_state`==1001.
- `ETH_INIT_IRQ_EN` defined:
  - Writes 92/FFFF and 90/2000 appear as the final two writes, then `done` pulses.
  - Every `reg_new_cmd` pulse is exactly 1 cycle wide.
